// File: rtl/census_pkg.sv
// Shared constants and helpers for the census window transform.
// CENSUS_TERNARY_EN selects the two-bit-per-neighbour ternary code.
package census_pkg;

`ifdef CENSUS_TERNARY_EN
  localparam bit TernaryEn = 1'b1;
`else
  localparam bit TernaryEn = 1'b0;
`endif

  // Cycles from an accepted beat to its out_valid.
  localparam int unsigned CENSUS_LAT = 2;

  function automatic int unsigned census_cw(int unsigned win, bit ternary);
    return ternary ? 2 * (win * win - 1) : win * win - 1;
  endfunction

  function automatic int unsigned census_half(int unsigned win);
    return (win - 1) / 2;
  endfunction

  // Saturates to 2^w-1.
  function automatic logic [31:0] sat_add(logic [31:0] a, logic [31:0] b, int unsigned w);
    logic [32:0] sum;
    logic [32:0] max_v;
    max_v = (33'd1 << w) - 33'd1;
    sum   = {1'b0, a} + {1'b0, b};
    return (sum > max_v) ? max_v[31:0] : sum[31:0];
  endfunction

  // Saturates to 0.
  function automatic logic [31:0] sat_sub(logic [31:0] a, logic [31:0] b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

endpackage

// File: rtl/census_linebuf.sv
// Simple dual-port line buffer: registered read with enable, synchronous write.
// Contents are never reset; only the read register is.
module census_linebuf #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned DW    = 8,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/census_window_xform.sv
// Parametrised census transform over a WIN x WIN window of a raster pixel stream.
// Optional ternary code via CENSUS_TERNARY_EN.
module census_window_xform
  import census_pkg::*;
#(
  parameter int unsigned PIX_W   = 8,
  parameter int unsigned WIN     = 5,
  parameter int unsigned LINE_W  = 1024,
  parameter int unsigned COORD_W = 13,
  parameter int unsigned T       = 8,
  localparam int unsigned CW     = census_cw(WIN, TernaryEn)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [PIX_W-1:0]   pix,
  input  logic [COORD_W-1:0] row,
  input  logic [COORD_W-1:0] col,
  output logic               out_valid,
  output logic [CW-1:0]      code,
  output logic [COORD_W-1:0] rowout,
  output logic [COORD_W-1:0] colout
);

  localparam int unsigned HALF = census_half(WIN);
  localparam int unsigned AW   = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int unsigned NB   = WIN * WIN - 1;
  localparam int unsigned CIDX = HALF * WIN + HALF;

  logic accept;
  logic emit;

  assign accept = in_valid && (32'(col) < LINE_W);
  assign emit   = accept && (32'(row) >= WIN - 1) && (32'(col) >= WIN - 1);

  // Newest window column: tap[WIN-1] is the live row, tap[r] comes from buffer WIN-1-r.
  logic [PIX_W-1:0]   tap [WIN];
  logic [PIX_W-1:0]   sh_q [WIN][WIN-1];
  logic [PIX_W-1:0]   pix_q;
  logic [AW-1:0]      wr_addr_q;
  logic               wr_en_q;
  logic [COORD_W-1:0] row1_q;
  logic [COORD_W-1:0] col1_q;

  assign tap[WIN-1] = pix_q;

  // Buffers write one cycle late, once their read register holds the column being passed down.
  for (genvar k = 1; k < WIN; k++) begin : g_lb
    census_linebuf #(
      .DEPTH (LINE_W),
      .DW    (PIX_W)
    ) u_linebuf (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_en   (accept),
      .rd_addr (col[AW-1:0]),
      .rd_data (tap[WIN-1-k]),
      .wr_en   (wr_en_q),
      .wr_addr (wr_addr_q),
      .wr_data (tap[WIN-k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < WIN; r++) begin
        for (int j = 0; j < WIN - 1; j++) begin
          sh_q[r][j] <= '0;
        end
      end
      pix_q     <= '0;
      wr_addr_q <= '0;
      wr_en_q   <= 1'b0;
      row1_q    <= '0;
      col1_q    <= '0;
    end else begin
      wr_en_q <= accept;
      if (accept) begin
        pix_q     <= pix;
        wr_addr_q <= col[AW-1:0];
        row1_q    <= row;
        col1_q    <= col;
        for (int r = 0; r < WIN; r++) begin
          sh_q[r][0] <= tap[r];
          for (int j = 1; j < WIN - 1; j++) begin
            sh_q[r][j] <= sh_q[r][j-1];
          end
        end
      end
    end
  end

  // win_c[r][x]: x = 0 is the leftmost (oldest) column.
  logic [PIX_W-1:0] win_c [WIN][WIN];

  for (genvar r = 0; r < WIN; r++) begin : g_wr
    for (genvar x = 0; x < WIN; x++) begin : g_wc
      if (x == WIN - 1) begin : g_new
        assign win_c[r][x] = tap[r];
      end else begin : g_old
        assign win_c[r][x] = sh_q[r][WIN-2-x];
      end
    end
  end

  logic [PIX_W-1:0] centre;
  logic [PIX_W-1:0] hi;
  logic [CW-1:0]    code_d;

  assign centre = win_c[HALF][HALF];
  assign hi     = PIX_W'(sat_add(32'(centre), T, PIX_W));

`ifdef CENSUS_TERNARY_EN
  logic [PIX_W-1:0] lo;
  assign lo = PIX_W'(sat_sub(32'(centre), T));
`endif

  // Row-major scan with the centre skipped; the newest (bottom-right) neighbour lands at bit 0.
  for (genvar r = 0; r < WIN; r++) begin : g_row
    for (genvar x = 0; x < WIN; x++) begin : g_col
      localparam int unsigned S = r * WIN + x;
      if (S != CIDX) begin : g_nb
        localparam int unsigned POS = NB - 1 - ((S < CIDX) ? S : S - 1);
`ifdef CENSUS_TERNARY_EN
        assign code_d[2*POS+1] = win_c[r][x] > hi;
        assign code_d[2*POS]   = win_c[r][x] < lo;
`else
        assign code_d[POS] = win_c[r][x] > hi;
`endif
      end
    end
  end

  logic [CENSUS_LAT-1:0] vpipe_q;

  assign out_valid = vpipe_q[CENSUS_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe_q <= '0;
      code    <= '0;
      rowout  <= '0;
      colout  <= '0;
    end else begin
      vpipe_q <= {vpipe_q[CENSUS_LAT-2:0], emit};
      if (vpipe_q[0]) begin
        code   <= code_d;
        rowout <= row1_q - COORD_W'(HALF);
        colout <= col1_q - COORD_W'(HALF);
      end
    end
  end

endmodule

// File: tb/tb_census_window_xform.sv
// Self-checking bench for census_window_xform against a frame-level census model.
module tb_census_window_xform;

  localparam int PIX_W   = 8;
  localparam int WIN     = 5;
  localparam int HALF    = 2;
  localparam int LINE_W  = 16;
  localparam int COORD_W = 13;
  localparam int T       = 8;
`ifdef CENSUS_TERNARY_EN
  localparam int CW = 2 * (WIN * WIN - 1);
`else
  localparam int CW = WIN * WIN - 1;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic [PIX_W-1:0]   pix;
  logic [COORD_W-1:0] row;
  logic [COORD_W-1:0] col;
  logic               out_valid;
  logic [CW-1:0]      code;
  logic [COORD_W-1:0] rowout;
  logic [COORD_W-1:0] colout;

  census_window_xform #(
    .PIX_W   (PIX_W),
    .WIN     (WIN),
    .LINE_W  (LINE_W),
    .COORD_W (COORD_W),
    .T       (T)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .pix       (pix),
    .row       (row),
    .col       (col),
    .out_valid (out_valid),
    .code      (code),
    .rowout    (rowout),
    .colout    (colout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int src [0:15][0:15];   // frame to send
  int img [0:15][0:15];   // pixels actually accepted

  bit            pend_v;
  logic [CW-1:0] pend_code;
  int            pend_r;
  int            pend_c;
  logic [CW-1:0] last_code;
  int            last_r;
  int            last_c;
  int            nvalid;
  logic [CW-1:0] cap44;
  logic [CW-1:0] cap88;
  logic [CW-1:0] exp44;
  logic [CW-1:0] exp88;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] model_code(int r, int c);
    logic [CW-1:0] res;
    int cv, hi, lo, n, nb, pos;
    res = '0;
    cv  = img[r-HALF][c-HALF];
    hi  = (cv + T > 255) ? 255 : cv + T;
    lo  = (cv - T < 0) ? 0 : cv - T;
    n   = 0;
    for (int dr = 0; dr < WIN; dr++) begin
      for (int dc = 0; dc < WIN; dc++) begin
        if (!(dr == HALF && dc == HALF)) begin
          nb  = img[r-WIN+1+dr][c-WIN+1+dc];
          pos = WIN * WIN - 2 - n;
`ifdef CENSUS_TERNARY_EN
          res[2*pos+1] = (nb > hi);
          res[2*pos]   = (nb < lo);
`else
          res[pos] = (nb > hi);
`endif
          n++;
        end
      end
    end
    return res;
  endfunction

  task automatic check_outputs();
    check("valid", 64'(out_valid), 64'(pend_v));
    if (pend_v) begin
      last_code = pend_code;
      last_r    = pend_r - HALF;
      last_c    = pend_c - HALF;
    end
    check("code", 64'(code), 64'(last_code));
    check("rowout", 64'(rowout), 64'(COORD_W'(last_r)));
    check("colout", 64'(colout), 64'(COORD_W'(last_c)));
    if (out_valid === 1'b1) begin
      nvalid++;
      if (rowout == 13'd4 && colout == 13'd4) cap44 = code;
      if (rowout == 13'd8 && colout == 13'd8) cap88 = code;
    end
  endtask

  // Called at a negedge; drives one cycle and checks the beat from the previous call.
  task automatic tick(input bit v, input int r, input int c, input int p);
    bit            acc;
    bit            nv;
    logic [CW-1:0] ncode;
    in_valid = v;
    row      = COORD_W'(r);
    col      = COORD_W'(c);
    pix      = PIX_W'(p);
    acc      = v && (c < LINE_W);
    if (acc) img[r][c] = p;
    nv    = acc && (r >= WIN - 1) && (c >= WIN - 1);
    ncode = nv ? model_code(r, c) : '0;
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    pend_v    = nv;
    pend_code = ncode;
    pend_r    = r;
    pend_c    = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b0, int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(255)));
    end
  endtask

  task automatic mid_reset();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", 64'(out_valid), 64'd0);
    check("rst_async_code", 64'(code), 64'd0);
    check("rst_async_rowout", 64'(rowout), 64'd0);
    check("rst_async_colout", 64'(colout), 64'd0);
    pend_v    = 1'b0;
    last_code = '0;
    last_r    = 0;
    last_c    = 0;
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
  endtask

  // stall: random 50% idle cycles; oor: extra col=20 beat mid-row; rst_mid: reset at (5,7).
  task automatic send_frame(input int rows, input int cols, input bit stall, input bit oor,
                            input bit rst_mid);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        if (rst_mid && r == 5 && c == 7) begin
          mid_reset();
          return;
        end
        if (stall) begin
          for (int s = 0; s < 6 && $urandom_range(1) == 1; s++) idle(1);
        end
        tick(1'b1, r, c, src[r][c]);
        if (oor && c == 10) tick(1'b1, r, 20, int'($urandom_range(255)));
      end
    end
    idle(3);
  endtask

  task automatic fill_const(input int v);
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) src[r][c] = v;
  endtask

  task automatic fill_rand(input int lo, input int hi);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) src[r][c] = int'($urandom_range(hi, lo));
  endtask

  task automatic fill_ext();
    int ext [8];
    ext = '{0, 1, 7, 8, 9, 247, 248, 255};
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) src[r][c] = ext[$urandom_range(7)];
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    pix       = '0;
    row       = '0;
    col       = '0;
    pend_v    = 1'b0;
    pend_code = '0;
    last_code = '0;
    last_r    = 0;
    last_c    = 0;
    nvalid    = 0;
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) img[r][c] = 0;

    repeat (2) @(negedge clk);
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_code", 64'(code), 64'd0);
    check("reset_rowout", 64'(rowout), 64'd0);
    check("reset_colout", 64'(colout), 64'd0);
    rst_n = 1'b1;
    idle(2);

    // Flat 16x8 frame: 4 rows x 12 columns of unmasked windows.
    fill_const(100);
    nvalid = 0;
    send_frame(8, 16, 1'b0, 1'b0, 1'b0);
    check("flat_count", 64'(nvalid), 64'd48);

    // Single bright pixel, without and with stalls.
`ifdef CENSUS_TERNARY_EN
    exp44 = CW'(2);
`else
    exp44 = CW'(1);
`endif
    exp88 = '0;
    exp88[CW-1] = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      fill_const(50);
      src[6][6] = 200;
      cap44 = '1;
      cap88 = '1;
      send_frame(12, 16, pass == 1, 1'b0, 1'b0);
      check("bright_c44", 64'(cap44), 64'(exp44));
      check("bright_c88", 64'(cap88), 64'(exp88));
    end

    // Saturation: hi clamps at 255, lo clamps at 0.
    fill_const(255);
    src[2][2] = 250;
    send_frame(8, 16, 1'b0, 1'b0, 1'b0);
`ifdef CENSUS_TERNARY_EN
    fill_const(0);
    src[2][2] = 3;
    send_frame(8, 16, 1'b0, 1'b0, 1'b0);
`endif

    // Random content: full range, near-threshold, and extremes.
    fill_rand(0, 255);
    send_frame(12, 16, 1'b1, 1'b0, 1'b0);
    fill_rand(92, 116);
    send_frame(12, 16, 1'b1, 1'b0, 1'b0);
    fill_ext();
    send_frame(10, 16, 1'b0, 1'b0, 1'b0);

    // Out-of-range column beats interleaved into a frame, then a clean frame.
    fill_rand(0, 255);
    send_frame(10, 16, 1'b0, 1'b1, 1'b0);
    fill_rand(90, 120);
    send_frame(10, 16, 1'b1, 1'b1, 1'b0);

    // Reset mid-frame, then a fresh frame must stay masked until beat (4,4).
    fill_rand(0, 255);
    send_frame(8, 16, 1'b0, 1'b0, 1'b1);
    fill_rand(80, 130);
    nvalid = 0;
    send_frame(8, 16, 1'b0, 1'b0, 1'b0);
    check("post_reset_count", 64'(nvalid), 64'd48);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/census_window_xform.md
Name: census_window_xform

Overview:
- Parametrised census-transform stage for the stereo pipeline; successor to the fixed 5x5, 8-bit census block.
- Sits between the grayscale pixel stream and the disparity cost/Hamming unit, one instance per camera.
- Adds:
  - configurable window, pixel width, line length and threshold
  - valid qualification with stall tolerance
  - asynchronous reset
  - explicit masking of incomplete border windows

Parameters:
- PIX_W, 8, pixel bit width.
- WIN, 5, window side; odd, 3..9; HALF = (WIN-1)/2.
- LINE_W, 1024, max columns per line; line-buffer depth.
- COORD_W, 13, row/col coordinate width.
- T, 8, comparison threshold, PIX_W bits.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  pix/row/col qualify this cycle.
- pix  in  PIX_W  grayscale pixel, raster order.
- row  in  COORD_W  row of pix.
- col  in  COORD_W  column of pix.
- out_valid  out  1  code/rowout/colout valid.
- code  out  CW  census code; CW = WIN*WIN-1 (2x with ternary, see Optional Feature).
- rowout  out  COORD_W  window-centre row = row-HALF.
- colout  out  COORD_W  window-centre column = col-HALF.

Behaviour:
- Reset (rst_n low, async): out_valid=0, code=0, rowout=0, colout=0; window registers and pipeline valid bits cleared. Line-buffer RAM is not cleared. Reset mid-frame drops in-flight beats; output resumes per the masking rule below.
- Beat acceptance: a beat is accepted when in_valid=1 and col<LINE_W. Beats with col>=LINE_W are ignored: no RAM write, no window shift, no output.
- Line buffers: WIN-1 cascaded buffers, LINE_W x PIX_W, addressed by col[clog2(LINE_W)-1:0].
  - Read before write, registered read, 1 cycle.
  - Buffer k input = buffer k-1 output; buffer 1 input = pix.
- Stage 1 (cycle after acceptance): each of the WIN window row shift registers shifts in one column: current pix for the bottom row, line-buffer outputs for the upper rows. No shift without an accepted beat, so stalls are lossless.
- Stage 2: census compare, registered.
  - lo = (c > T) ? c-T : 0
  - hi = (c < 2^PIX_W-1-T) ? c+T : 2^PIX_W-1 (saturating)
  - c = window centre pixel.
  - Binary bit = neighbour > hi.
  - Equal-to-bound counts as not greater.
- Bit order: neighbours scanned row-major from top-left to bottom-right, centre skipped. Bottom-right (newest) is bit 0; top-left is MSB.
- Latency: out_valid asserts exactly 2 cycles after an accepted beat at (row, col), provided row>=WIN-1 and col>=WIN-1. Otherwise out_valid stays 0 for that beat (border windows masked, stale RAM never emitted).
- The valid pipeline runs freely, independent of later in_valid. Output fields hold their last value while out_valid=0.
- Coordinates: rowout/colout = row-HALF, col-HALF (COORD_W modulo), registered alongside code.
- Back-to-back frames: no special reset; row=0 beats are masked naturally.

Optional Feature:
- Macro: CENSUS_TERNARY_EN.
- Defined: each neighbour yields 2 bits {neighbour>hi, neighbour<lo}. CW = 2*(WIN*WIN-1), neighbour i occupies bits [2i+1:2i]. A neighbour inside [lo,hi] yields 00.
- Undefined: binary code only, CW = WIN*WIN-1; the lo computation is removed.

Decomposition:
- Package census_pkg holds:
  - function census_cw(win, ternary) returning CW
  - HALF derivation
  - saturating add/sub helper functions sat_add/sat_sub (PIX_W generic)
  - CENSUS_LAT = 2 constant
- Sub-module census_linebuf: one simple dual-port RAM with registered read and write enable, instantiated WIN-1 times via generate.

Test Plan:
- Flat image, all pixels 100, T=8, WIN=5, 16x8 frame: out_valid first asserts 2 cycles after beat (4,4) with rowout=2, colout=2, code=0. Exactly 4x12=48 valid outputs.
- Single bright pixel: 200 at (6,6), rest 50. Centre (4,4) (beat (6,6)) code has bit 0 set only. Centre (6,6) code=0. Centre (8,8) code has MSB only.
- Saturation: centre 250, T=8, neighbours 255 -> code=0 (hi clamps to 255). Centre 3 with CENSUS_TERNARY_EN, neighbours 0 -> every pair 00 (lo clamps to 0).
- Stalls: same image as the single-bright-pixel test with in_valid toggled by a random 50% pattern -> output code/coordinate sequence identical to the no-stall run; each out_valid exactly 2 cycles after its beat.
- Reset mid-frame: assert rst_n low at beat (5,7) -> out_valid=0 and code=0 immediately (async). After release with a new frame starting at (0,0), no output before beat (4,4).
- Out-of-range column: LINE_W=16, beat with col=20 -> no out_valid, RAM column 4 unchanged (verified by a following frame's codes).
